regfile_sequencer: RTL and testbench

// Multi-cycle fetch/decode/execute controller for the 16-bit core register file.

---
 rtl/regfile_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// ============================================================================
// Module      : regfile_sequencer
// Description : Multi-cycle fetch/decode/execute controller for the 16-bit
//               core register file. Fetches over a req/ack memory port using
//               the PC (R7) read through regfile port 0, then steers the
//               regfile selects, write enable, PC increment, ALU op and
//               immediate for one instruction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module regfile_sequencer #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] rd0,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [2:0]  regr0s,
   output logic [2:0]  regr1s,
   output logic [2:0]  regws,
   output logic        we,
   output logic        incr_pc,
   output logic [2:0]  alu_op,
   output logic [15:0] imm,
   output logic        wb_sel,
   output logic        halted,
   output logic        fault
);

   // FSM state encoding
   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_FETCH  = 3'd1;
   localparam logic [2:0] c_ST_WAIT   = 3'd2;
   localparam logic [2:0] c_ST_DECODE = 3'd3;
   localparam logic [2:0] c_ST_EXEC   = 3'd4;
   localparam logic [2:0] c_ST_WB     = 3'd5;
   localparam logic [2:0] c_ST_HALTED = 3'd6;
   localparam logic [2:0] c_ST_FAULT  = 3'd7;

   // Opcodes
   localparam logic [3:0] c_OP_ADD = 4'h1;
   localparam logic [3:0] c_OP_SUB = 4'h2;
   localparam logic [3:0] c_OP_AND = 4'h3;
   localparam logic [3:0] c_OP_OR  = 4'h4;
   localparam logic [3:0] c_OP_LDI = 4'h5;
   localparam logic [3:0] c_OP_BR  = 4'h6;
   localparam logic [3:0] c_OP_HLT = 4'hF;

   // ALU operation codes
   localparam logic [2:0] c_ALU_ADD = 3'd0;
   localparam logic [2:0] c_ALU_SUB = 3'd1;
   localparam logic [2:0] c_ALU_AND = 3'd2;
   localparam logic [2:0] c_ALU_OR  = 3'd3;

   // R7 holds the program counter
   localparam logic [2:0]  c_PC_REG    = 3'd7;
   // Last WAIT cycle count that may still accept an ack
   localparam logic [15:0] c_WAIT_LAST = 16'(ACK_TIMEOUT - 1);

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;

   // Only opcode and destination are needed after DECODE; the rest of the
   // instruction word is consumed directly into the select/imm registers.
   logic [3:0]  r_ir_op;
   logic [2:0]  r_ir_rd;
   logic [15:0] r_wait_cnt;
   logic        w_timeout;

   logic        r_mem_req;
   logic [15:0] r_mem_addr;
   logic [2:0]  r_regr0s;
   logic [2:0]  r_regr1s;
   logic [2:0]  r_regws;
   logic        r_we;
   logic        r_incr_pc;
   logic [2:0]  r_alu_op;
   logic [15:0] r_imm;
   logic        r_wb_sel;
   logic        r_halted;
   logic        r_fault;

   logic        w_mem_req_nxt;
   logic [15:0] w_mem_addr_nxt;
   logic [2:0]  w_regr0s_nxt;
   logic [2:0]  w_regr1s_nxt;
   logic [2:0]  w_regws_nxt;
   logic        w_we_nxt;
   logic        w_incr_pc_nxt;
   logic [2:0]  w_alu_op_nxt;
   logic [15:0] w_imm_nxt;
   logic        w_wb_sel_nxt;
   logic        w_halted_nxt;
   logic        w_fault_nxt;
   logic [3:0]  w_ir_op_nxt;
   logic [2:0]  w_ir_rd_nxt;
   logic [15:0] w_wait_cnt_nxt;

   logic [15:0] w_sext9;
   logic [2:0]  w_dec_alu_op;
   logic [15:0] w_dec_imm;
   logic        w_dec_wb_sel;
   logic        w_wb_we;
   logic [2:0]  w_wb_regws;
   logic        w_wb_incr_pc;

   assign w_timeout = (r_wait_cnt == c_WAIT_LAST);
   assign w_sext9   = {{7{mem_rdata[8]}}, mem_rdata[8:0]};

   // Decode the incoming instruction word for the values latched on entry to DECODE
   always_comb begin
      w_dec_alu_op = c_ALU_ADD;
      w_dec_imm    = 16'h0000;
      w_dec_wb_sel = 1'b0;
      case (mem_rdata[15:12])
         c_OP_ADD: w_dec_alu_op = c_ALU_ADD;
         c_OP_SUB: w_dec_alu_op = c_ALU_SUB;
         c_OP_AND: w_dec_alu_op = c_ALU_AND;
         c_OP_OR:  w_dec_alu_op = c_ALU_OR;
         c_OP_LDI: begin
            w_dec_imm    = w_sext9;
            w_dec_wb_sel = 1'b1;
         end
         c_OP_BR: begin
            w_dec_imm    = {w_sext9[14:0], 1'b0};
            w_dec_wb_sel = 1'b1;
         end
         default: ;
      endcase
   end

   // Writeback strobes from the latched opcode; a write to R7 suppresses the PC increment
   always_comb begin
      w_wb_we    = 1'b0;
      w_wb_regws = 3'd0;
      case (r_ir_op)
         c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_LDI: begin
            w_wb_regws = r_ir_rd;
            w_wb_we    = (r_ir_rd != 3'd0);
         end
         c_OP_BR: begin
            w_wb_regws = c_PC_REG;
            w_wb_we    = 1'b1;
         end
         default: ;
      endcase
      w_wb_incr_pc = (r_ir_op != c_OP_HLT) && !(w_wb_we && (w_wb_regws == c_PC_REG));
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:   if (run) w_state_nxt = c_ST_FETCH;
         c_ST_FETCH:  w_state_nxt = c_ST_WAIT;
         c_ST_WAIT: begin
            if (mem_ack) begin
               w_state_nxt = c_ST_DECODE;
            end else if (w_timeout) begin
               w_state_nxt = c_ST_FAULT;
            end
         end
         c_ST_DECODE: w_state_nxt = c_ST_EXEC;
         c_ST_EXEC:   w_state_nxt = c_ST_WB;
         c_ST_WB: begin
            if (r_ir_op == c_OP_HLT) begin
               w_state_nxt = c_ST_HALTED;
            end else if (run) begin
               w_state_nxt = c_ST_FETCH;
            end else begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_HALTED: w_state_nxt = c_ST_HALTED;
         c_ST_FAULT:  w_state_nxt = c_ST_FAULT;
         default:     w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs, keyed on the transition taken
   always_comb begin
      w_mem_req_nxt  = r_mem_req;
      w_mem_addr_nxt = r_mem_addr;
      w_regr0s_nxt   = r_regr0s;
      w_regr1s_nxt   = r_regr1s;
      w_regws_nxt    = r_regws;
      w_we_nxt       = 1'b0;
      w_incr_pc_nxt  = 1'b0;
      w_alu_op_nxt   = r_alu_op;
      w_imm_nxt      = r_imm;
      w_wb_sel_nxt   = r_wb_sel;
      w_halted_nxt   = r_halted;
      w_fault_nxt    = r_fault;
      w_ir_op_nxt    = r_ir_op;
      w_ir_rd_nxt    = r_ir_rd;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         c_ST_IDLE: begin
            // point port 0 at the PC for the coming FETCH cycle
            if (run) w_regr0s_nxt = c_PC_REG;
         end
         c_ST_FETCH: begin
            w_mem_addr_nxt = rd0;
            w_mem_req_nxt  = 1'b1;
            w_wait_cnt_nxt = 16'd0;
         end
         c_ST_WAIT: begin
            if (mem_ack) begin
               w_mem_req_nxt = 1'b0;
               w_ir_op_nxt   = mem_rdata[15:12];
               w_ir_rd_nxt   = mem_rdata[11:9];
               w_regr0s_nxt  = mem_rdata[8:6];
               w_regr1s_nxt  = mem_rdata[5:3];
               w_alu_op_nxt  = w_dec_alu_op;
               w_imm_nxt     = w_dec_imm;
               w_wb_sel_nxt  = w_dec_wb_sel;
            end else if (w_timeout) begin
               w_mem_req_nxt = 1'b0;
               w_fault_nxt   = 1'b1;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 16'd1;
            end
         end
         c_ST_EXEC: begin
            w_we_nxt      = w_wb_we;
            w_incr_pc_nxt = w_wb_incr_pc;
            w_regws_nxt   = w_wb_regws;
         end
         c_ST_WB: begin
            if (r_ir_op == c_OP_HLT) begin
               w_halted_nxt = 1'b1;
            end else if (run) begin
               w_regr0s_nxt = c_PC_REG;
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers; reset clears everything including sticky flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_req  <= 1'b0;
         r_mem_addr <= 16'h0000;
         r_regr0s   <= 3'd0;
         r_regr1s   <= 3'd0;
         r_regws    <= 3'd0;
         r_we       <= 1'b0;
         r_incr_pc  <= 1'b0;
         r_alu_op   <= 3'd0;
         r_imm      <= 16'h0000;
         r_wb_sel   <= 1'b0;
         r_halted   <= 1'b0;
         r_fault    <= 1'b0;
         r_ir_op    <= 4'h0;
         r_ir_rd    <= 3'd0;
         r_wait_cnt <= 16'd0;
      end else begin
         r_mem_req  <= w_mem_req_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_regr0s   <= w_regr0s_nxt;
         r_regr1s   <= w_regr1s_nxt;
         r_regws    <= w_regws_nxt;
         r_we       <= w_we_nxt;
         r_incr_pc  <= w_incr_pc_nxt;
         r_alu_op   <= w_alu_op_nxt;
         r_imm      <= w_imm_nxt;
         r_wb_sel   <= w_wb_sel_nxt;
         r_halted   <= w_halted_nxt;
         r_fault    <= w_fault_nxt;
         r_ir_op    <= w_ir_op_nxt;
         r_ir_rd    <= w_ir_rd_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;
   assign regr0s   = r_regr0s;
   assign regr1s   = r_regr1s;
   assign regws    = r_regws;
   assign we       = r_we;
   assign incr_pc  = r_incr_pc;
   assign alu_op   = r_alu_op;
   assign imm      = r_imm;
   assign wb_sel   = r_wb_sel;
   assign halted   = r_halted;
   assign fault    = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Scoreboard bench for regfile_sequencer. A small instruction
//               memory serves words in issue order with per-word ack delay;
//               a negedge monitor pops the expected response per fetch and
//               checks DECODE selects and the WB strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_sequencer;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [15:0] rd0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [2:0]  regr0s;
   logic [2:0]  regr1s;
   logic [2:0]  regws;
   logic        we;
   logic        incr_pc;
   logic [2:0]  alu_op;
   logic [15:0] imm;
   logic        wb_sel;
   logic        halted;
   logic        fault;

   typedef struct {
      logic [15:0] addr;
      logic [2:0]  r0s;
      logic [2:0]  r1s;
      logic [2:0]  alu;
      logic [15:0] imm;
      logic        wb;
      logic        we;
      logic [2:0]  ws;
      logic        inc;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] prog_addr [16];
   logic [15:0] prog_word [16];
   int          prog_delay[16];
   logic [3:0]  fetch_idx = 4'd0;
   int          bw = 0;
   logic        ack_en = 1'b1;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   regfile_sequencer #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .run(run), .rd0(rd0),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .regr0s(regr0s), .regr1s(regr1s), .regws(regws), .we(we), .incr_pc(incr_pc),
      .alu_op(alu_op), .imm(imm), .wb_sel(wb_sel), .halted(halted), .fault(fault)
   );

   // Memory / PC model: words are served in issue order, each after its own delay
   assign rd0       = prog_addr[fetch_idx];
   assign mem_rdata = prog_word[fetch_idx];
   assign mem_ack   = mem_req && ack_en && (bw >= prog_delay[fetch_idx]);

   always @(posedge clk) begin
      if (reset || !mem_req || mem_ack) bw <= 0;
      else bw <= bw + 1;
      if (!reset && mem_req && mem_ack) fetch_idx <= fetch_idx + 4'd1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic rst_check(input string tag);
      check({tag, "_addr_imm"}, {mem_addr, imm}, 32'h0);
      check({tag, "_ctl"}, {mem_req, regr0s, regr1s, regws, we, incr_pc, alu_op,
                            wb_sel, halted, fault}, 32'h0);
   endtask

   task automatic issue(input int idx, input logic [15:0] addr, input logic [15:0] word,
                        input int dly, input logic [2:0] r0s, input logic [2:0] r1s,
                        input logic [2:0] alu, input logic [15:0] imv, input logic wb,
                        input logic wev, input logic [2:0] ws, input logic inc);
      exp_t e;
      prog_addr[idx]  = addr;
      prog_word[idx]  = word;
      prog_delay[idx] = dly;
      e.addr = addr; e.r0s = r0s; e.r1s = r1s; e.alu = alu; e.imm = imv;
      e.wb = wb; e.we = wev; e.ws = ws; e.inc = inc;
      exp_q.push_back(e);
   endtask

   // Monitor: a fetch handshake starts a transaction; DECODE, EXEC and WB follow on consecutive cycles
   int   phase = 0;
   exp_t cur;
   always @(negedge clk) begin
      if (reset) begin
         phase = 0;
      end else begin
         case (phase)
            0: begin
               check("no_strobe_idle", {we, incr_pc}, 0);
               if (mem_req && mem_ack) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_errors++;
                     $display("FAIL unexpected_fetch: addr 0x%0h with empty scoreboard", mem_addr);
                  end else begin
                     cur = exp_q.pop_front();
                     check("fetch_addr", mem_addr, cur.addr);
                     phase = 1;
                  end
               end
            end
            1: begin
               check("dec_regr0s", regr0s, cur.r0s);
               check("dec_regr1s", regr1s, cur.r1s);
               check("no_strobe_dec", {we, incr_pc}, 0);
               phase = 2;
            end
            2: begin
               check("no_strobe_exec", {we, incr_pc}, 0);
               phase = 3;
            end
            default: begin
               check("wb_we", we, cur.we);
               check("wb_incr_pc", incr_pc, cur.inc);
               if (cur.we) check("wb_regws", regws, cur.ws);
               check("wb_alu_op", alu_op, cur.alu);
               check("wb_imm", imm, cur.imm);
               check("wb_sel", wb_sel, cur.wb);
               phase = 0;
            end
         endcase
      end
   end

   task automatic wait_handshake(input string name);
      int n = 0;
      while (!(mem_req && mem_ack) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_seen"}, (mem_req && mem_ack), 1);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) begin
         prog_addr[i] = 16'h0; prog_word[i] = 16'h0; prog_delay[i] = 0;
      end
      //       idx addr     word     dly   r0s r1s alu imm      wb we ws inc
      issue(0,  16'h0000, 16'h1298, 0,    2,  3,  0,  16'h0000, 0, 1, 1, 1); // ADD r1
      issue(1,  16'h0002, 16'h2A50, 3,    1,  2,  1,  16'h0000, 0, 1, 5, 1); // SUB r5
      issue(2,  16'h0004, 16'h51FF, 0,    7,  7,  0,  16'hFFFF, 1, 0, 0, 1); // LDI r0
      issue(3,  16'h0006, 16'h57FF, TO-1, 7,  7,  0,  16'hFFFF, 1, 1, 3, 1); // LDI r3, late ack
      issue(4,  16'h0008, 16'h60FF, 1,    3,  7,  0,  16'h01FE, 1, 1, 7, 0); // BR +
      issue(5,  16'h01FE, 16'h3000, 0,    0,  0,  2,  16'h0000, 0, 0, 0, 1); // AND r0
      issue(6,  16'h0200, 16'h4E38, 0,    0,  7,  3,  16'h0000, 0, 1, 7, 0); // OR r7
      issue(7,  16'h0202, 16'h7E00, 2,    0,  0,  0,  16'h0000, 0, 0, 0, 1); // illegal
      issue(8,  16'h0204, 16'h6100, 0,    4,  0,  0,  16'hFE00, 1, 1, 7, 0); // BR -
      issue(9,  16'h0206, 16'hF000, 0,    0,  0,  0,  16'h0000, 0, 0, 0, 0); // HLT

      // reset state
      repeat (2) @(posedge clk);
      #1 rst_check("reset");

      // run from reset: FETCH, then request, WB on the fifth edge
      run = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      check("fetch_no_req", mem_req, 0);
      check("fetch_regr0s_pc", regr0s, 7);
      @(posedge clk); #1;
      check("req_after_fetch", mem_req, 1);
      check("req_addr", mem_addr, 16'h0000);
      repeat (3) @(posedge clk);
      #1 check("wb_on_fifth_edge", we, 1);

      n = 0;
      while (!halted && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("halted", halted, 1);
      check("no_fault", fault, 0);
      check("scoreboard_drained", exp_q.size(), 0);
      n = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (mem_req || !halted) n++;
      end
      check("halted_terminal", n, 0);

      // reset clears halted; drop run mid-instruction
      issue(10, 16'h0300, 16'h1298, 0,    2,  3,  0,  16'h0000, 0, 1, 1, 1);
      issue(11, 16'h0302, 16'h2A50, 2,    1,  2,  1,  16'h0000, 0, 1, 5, 1);
      reset = 1'b1; run = 1'b0;
      @(posedge clk); #1 rst_check("reset_halted");
      reset = 1'b0; run = 1'b1;
      wait_handshake("hs10");
      @(posedge clk); #1 run = 1'b0;
      repeat (3) @(posedge clk);
      n = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (mem_req) n++;
      end
      check("idle_after_run_drop", n, 0);

      // reset during EXEC abandons the instruction
      run = 1'b1;
      wait_handshake("hs11");
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b1; run = 1'b0;
      @(posedge clk); #1 rst_check("reset_exec");
      reset = 1'b0;
      n = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (mem_req || we || incr_pc) n++;
      end
      check("quiet_after_reset", n, 0);

      // fetch timeout
      ack_en = 1'b0; run = 1'b1;
      n = 0;
      while (!mem_req && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n = 0;
      while (mem_req && n < 4 * TO) begin
         n++;
         @(posedge clk); #1;
      end
      check("req_cycles_before_fault", n, TO);
      check("fault_set", fault, 1);
      check("req_dropped", mem_req, 0);
      n = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (mem_req || !fault || we || incr_pc) n++;
      end
      check("fault_terminal", n, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
